// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types and constants for the OTTER memory arbiter
package otter_mem_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        PROG  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } rd_owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // 2'b11 is not a defined access size on the OTTER memory port.
    function automatic logic size_legal(input logic [1:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
    endfunction

endpackage

// File: rtl/otter_mem_arbiter_starve_counter.sv
// rtl/otter_mem_arbiter_starve_counter.sv - saturating count of consecutive denied fetch cycles
module starve_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [3:0] MAX_CNT = 4'(MAX);

    logic [3:0] cnt;

    assign at_max = (cnt == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - single-port memory arbiter for fetch, data and programmer access
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_RVALID,
    output logic [DW-1:0] IF_RDATA,

    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WDATA,
    input  logic [1:0]    DM_SIZE,
    input  logic          DM_SIGN,
    output logic          DM_GNT,
    output logic          DM_RVALID,
    output logic [DW-1:0] DM_RDATA,

    input  logic          PRG_MODE,
    input  logic          PRG_REQ,
    input  logic [AW-1:0] PRG_ADDR,
    input  logic [DW-1:0] PRG_WDATA,
    output logic          PRG_GNT,

    output logic          CPU_HOLD,

    output logic          MEM_RE,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DIN,
    output logic [1:0]    MEM_SIZE,
    output logic          MEM_SIGN,
    input  logic [DW-1:0] MEM_DOUT
);

    arb_state_t state_q, state_d;
    rd_owner_t  owner_q, owner_d;

    logic if_gnt, dm_gnt, prg_gnt;
    logic starve_at_max;
    logic starve_inc, starve_clr;

    // Counting only happens in RUN; any other state parks the counter at 0 so RUN is re-entered clean.
    assign starve_inc = (state_q == RUN) && IF_REQ && !if_gnt;
    assign starve_clr = (state_q != RUN) || !IF_REQ || if_gnt;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (CLK),
        .rst_n  (RST),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        prg_gnt = 1'b0;
        case (state_q)
            RUN: begin
                // The cycle PRG_MODE rises still arbitrates; its read returns during DRAIN.
                if (RST) begin
                    if (IF_REQ && (starve_at_max || !DM_REQ)) begin
                        if_gnt = 1'b1;
                    end else if (DM_REQ) begin
                        dm_gnt = 1'b1;
                    end
                end
                if (PRG_MODE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = PROG;
            end
            PROG: begin
                prg_gnt = RST && PRG_REQ;
                if (!PRG_MODE) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        MEM_RE   = 1'b0;
        MEM_WE   = 1'b0;
        MEM_ADDR = '0;
        MEM_DIN  = '0;
        MEM_SIZE = SZ_BYTE;
        MEM_SIGN = 1'b0;
        if (if_gnt) begin
            MEM_RE   = 1'b1;
            MEM_ADDR = IF_ADDR;
            MEM_SIZE = SZ_WORD;
        end else if (dm_gnt) begin
            MEM_RE   = !DM_WE;
            MEM_WE   = DM_WE;
            MEM_ADDR = DM_ADDR;
            MEM_DIN  = DM_WE ? DM_WDATA : '0;
            MEM_SIZE = DM_SIZE;
            MEM_SIGN = DM_SIGN;
        end else if (prg_gnt) begin
            MEM_WE   = 1'b1;
            MEM_ADDR = PRG_ADDR;
            MEM_DIN  = PRG_WDATA;
            MEM_SIZE = SZ_WORD;
        end
    end

    // The tag names the owner of the read issued this cycle; writes and idle cycles leave NONE.
    always_comb begin
        owner_d = NONE;
        if (if_gnt) begin
            owner_d = IF;
        end else if (dm_gnt && !DM_WE) begin
            owner_d = DM;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RUN;
            owner_q <= NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign IF_GNT    = if_gnt;
    assign DM_GNT    = dm_gnt;
    assign PRG_GNT   = prg_gnt;
    assign CPU_HOLD  = (state_q != RUN);

    assign IF_RVALID = (owner_q == IF);
    assign DM_RVALID = (owner_q == DM);
    assign IF_RDATA  = IF_RVALID ? MEM_DOUT : '0;
    assign DM_RDATA  = DM_RVALID ? MEM_DOUT : '0;

endmodule
